buffer_write_arbiter: RTL and testbench

- Single-clock scheduler that shares the write port of the switch's 16-bit packet buffer RAM between NUM_PORTS ingress requesters.
- Uses round-robin arbitration with packet lock: the granted port keeps the write port until its last word is accepted.
- Owns the circular write pointer and the free-word count.
- Emits one descriptor (port, start address, length) per stored packet, for the egress queueing logic.

---
 rtl/buffer_write_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_buffer_write_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : buffer_write_arbiter
// Purpose  : Round-robin, packet-locked scheduler for the write port of the
//            shared packet buffer. Owns the circular write pointer and the
//            free-word count. Emits one descriptor per stored packet.
// Options  : define BUFFER_WRITE_ARBITER_STATS_EN to add word/packet counters
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module buffer_write_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        i_req_valid,
  input  logic [NUM_PORTS-1:0]        i_req_last,
  input  logic [NUM_PORTS*DATA_W-1:0] i_req_data,
  output logic [NUM_PORTS-1:0]        o_req_ready,
  input  logic [ADDR_W:0]             i_release_cnt,
  output logic                        o_mem_wen,
  output logic [ADDR_W-1:0]           o_mem_waddr,
  output logic [DATA_W-1:0]           o_mem_wdata,
  output logic                        o_pkt_done,
  output logic [2:0]                  o_pkt_port,
  output logic [ADDR_W-1:0]           o_pkt_start,
  output logic [ADDR_W:0]             o_pkt_len,
  output logic [ADDR_W:0]             o_free_words
`ifdef BUFFER_WRITE_ARBITER_STATS_EN
  ,
  input  logic                        i_stat_clr,
  output logic [31:0]                 o_stat_words,
  output logic [31:0]                 o_stat_pkts
`endif
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  // Depth expressed in the free-count width and in the wider sum width
  localparam logic [ADDR_W:0]   c_DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W+1:0] c_DEPTH_W = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   c_ONE_L   = 1;
  localparam logic [ADDR_W-1:0] c_ONE_A   = 1;

  state_t              r_state;
  logic [2:0]          r_grant;
  logic [2:0]          r_rr_last;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_free;
  logic [ADDR_W:0]     r_len_cnt;
  logic                r_mem_wen;
  logic [ADDR_W-1:0]   r_mem_waddr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_pkt_done;
  logic [2:0]          r_pkt_port;
  logic [ADDR_W-1:0]   r_pkt_start;
  logic [ADDR_W:0]     r_pkt_len;

  logic                w_gvalid;
  logic                w_glast;
  logic [DATA_W-1:0]   w_gdata;
  logic                w_accept;
  logic                w_found;
  logic [2:0]          w_winner;
  logic [ADDR_W+1:0]   w_free_sum;
  logic [ADDR_W:0]     w_free_next;

  // Select the granted port's request signals
  always_comb begin
    w_gvalid = 1'b0;
    w_glast  = 1'b0;
    w_gdata  = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant == 3'(i)) begin
        w_gvalid = i_req_valid[i];
        w_glast  = i_req_last[i];
        w_gdata  = i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Ready depends only on registered state: granted port, burst, space left
  always_comb begin
    o_req_ready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      o_req_ready[i] = (r_state == S_BURST) && (r_grant == 3'(i)) && (r_free != '0);
    end
  end

  assign w_accept = (r_state == S_BURST) && w_gvalid && (r_free != '0);

  // Round-robin scan starting one past the last winner, wrapping modulo NUM_PORTS
  always_comb begin
    int v_idx;
    w_found  = 1'b0;
    w_winner = '0;
    v_idx    = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      v_idx = (int'(r_rr_last) + k) % NUM_PORTS;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (!w_found && (j == v_idx) && i_req_valid[j]) begin
          w_found  = 1'b1;
          w_winner = 3'(j);
        end
      end
    end
  end

  // Free count: consume accepted word, add released words, clamp at depth
  always_comb begin
    w_free_sum  = {1'b0, r_free} - {{(ADDR_W+1){1'b0}}, w_accept} + {1'b0, i_release_cnt};
    w_free_next = (w_free_sum > c_DEPTH_W) ? c_DEPTH : w_free_sum[ADDR_W:0];
  end

  // Arbitration FSM, write path, pointer/length tracking and descriptor output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_rr_last   <= 3'(NUM_PORTS - 1);
      r_wr_ptr    <= '0;
      r_free      <= c_DEPTH;
      r_len_cnt   <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      r_pkt_done  <= 1'b0;
      r_pkt_port  <= '0;
      r_pkt_start <= '0;
      r_pkt_len   <= '0;
    end else begin
      r_mem_wen  <= w_accept;
      r_pkt_done <= w_accept && w_glast;
      r_free     <= w_free_next;
      if (w_accept) begin
        r_mem_waddr <= r_wr_ptr;
        r_mem_wdata <= w_gdata;
        r_wr_ptr    <= r_wr_ptr + c_ONE_A;
        r_len_cnt   <= r_len_cnt + c_ONE_L;
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_winner;
            r_rr_last   <= w_winner;
            r_pkt_start <= r_wr_ptr;
            r_len_cnt   <= '0;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_accept && w_glast) begin
            r_pkt_port <= r_grant;
            r_pkt_len  <= r_len_cnt + c_ONE_L;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_wen    = r_mem_wen;
  assign o_mem_waddr  = r_mem_waddr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_pkt_done   = r_pkt_done;
  assign o_pkt_port   = r_pkt_port;
  assign o_pkt_start  = r_pkt_start;
  assign o_pkt_len    = r_pkt_len;
  assign o_free_words = r_free;

`ifdef BUFFER_WRITE_ARBITER_STATS_EN
  logic [31:0] r_stat_words;
  logic [31:0] r_stat_pkts;

  // Statistics counters; clear wins over a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_words <= '0;
      r_stat_pkts  <= '0;
    end else if (i_stat_clr) begin
      r_stat_words <= '0;
      r_stat_pkts  <= '0;
    end else begin
      if (w_accept)   r_stat_words <= r_stat_words + 32'd1;
      if (r_pkt_done) r_stat_pkts  <= r_stat_pkts + 32'd1;
    end
  end

  assign o_stat_words = r_stat_words;
  assign o_stat_pkts  = r_stat_pkts;
`endif

endmodule

`default_nettype wire

// File: tb/tb_buffer_write_arbiter.sv
//------------------------------------------------------------------------------
// Module   : tb_buffer_write_arbiter
// Purpose  : Directed self-checking bench for buffer_write_arbiter (ADDR_W=4)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_buffer_write_arbiter;

  localparam int NP = 4;
  localparam int AW = 4;
  localparam int DW = 16;

  logic              clk;
  logic              rst_n;
  logic [NP-1:0]     valid;
  logic [NP-1:0]     last;
  logic [NP*DW-1:0]  data;
  logic [NP-1:0]     ready;
  logic [AW:0]       rel;
  logic              wen;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic              done;
  logic [2:0]        pport;
  logic [AW-1:0]     pstart;
  logic [AW:0]       plen;
  logic [AW:0]       free;
`ifdef BUFFER_WRITE_ARBITER_STATS_EN
  logic              sclr;
  logic [31:0]       swords;
  logic [31:0]       spkts;
`endif

  int checks = 0;
  int errors = 0;

  buffer_write_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req_valid   (valid),
    .i_req_last    (last),
    .i_req_data    (data),
    .o_req_ready   (ready),
    .i_release_cnt (rel),
    .o_mem_wen     (wen),
    .o_mem_waddr   (waddr),
    .o_mem_wdata   (wdata),
    .o_pkt_done    (done),
    .o_pkt_port    (pport),
    .o_pkt_start   (pstart),
    .o_pkt_len     (plen),
    .o_free_words  (free)
`ifdef BUFFER_WRITE_ARBITER_STATS_EN
    ,
    .i_stat_clr    (sclr),
    .o_stat_words  (swords),
    .o_stat_pkts   (spkts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one word on port p and return at the negedge after it is accepted
  task automatic push(input int p, input logic [15:0] d, input logic l);
    int n;
    n = 0;
    valid[p] = 1'b1;
    last[p]  = l;
    data[p*DW +: DW] = d;
    while (!ready[p] && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(ready[p]), 1);
    @(negedge clk);
    valid[p] = 1'b0;
    last[p]  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = '0;
    last  = '0;
    rel   = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    valid = '0;
    last  = '0;
    data  = '0;
    rel   = '0;
`ifdef BUFFER_WRITE_ARBITER_STATS_EN
    sclr  = 1'b0;
`endif
    repeat (2) @(negedge clk);

    // Reset values
    chk("rst_ready", 32'(ready), 0);
    chk("rst_wen", 32'(wen), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_port", 32'(pport), 0);
    chk("rst_start", 32'(pstart), 0);
    chk("rst_len", 32'(plen), 0);
    chk("rst_free", 32'(free), 16);
    rst_n = 1'b1;

    // Port 0 sends A,B,C
    push(0, 16'hA0A0, 1'b0);
    chk("t1_wen0", 32'(wen), 1);
    chk("t1_addr0", 32'(waddr), 0);
    chk("t1_data0", 32'(wdata), 'hA0A0);
    chk("t1_done0", 32'(done), 0);
    push(0, 16'hB0B0, 1'b0);
    chk("t1_wen1", 32'(wen), 1);
    chk("t1_addr1", 32'(waddr), 1);
    chk("t1_data1", 32'(wdata), 'hB0B0);
    push(0, 16'hC0C0, 1'b1);
    chk("t1_addr2", 32'(waddr), 2);
    chk("t1_data2", 32'(wdata), 'hC0C0);
    chk("t1_done", 32'(done), 1);
    chk("t1_port", 32'(pport), 0);
    chk("t1_start", 32'(pstart), 0);
    chk("t1_len", 32'(plen), 3);
    chk("t1_ready_idle", 32'(ready), 0);
    chk("t1_free", 32'(free), 13);
    @(negedge clk);
    chk("t1_wen_pulse", 32'(wen), 0);
    chk("t1_done_pulse", 32'(done), 0);

    // Ports 1 and 3 contend from reset: 1, 3, then 1, 3 again
    do_reset();
    valid = 4'b1010;
    last  = 4'b1010;
    data[16 +: 16] = 16'h1111;
    data[48 +: 16] = 16'h3333;
    @(negedge clk);
    chk("t2_ready_p1", 32'(ready), 'b0010);
    @(negedge clk);
    chk("t2_done_a", 32'(done), 1);
    chk("t2_port_a", 32'(pport), 1);
    chk("t2_addr_a", 32'(waddr), 0);
    chk("t2_data_a", 32'(wdata), 'h1111);
    valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_ready_p3", 32'(ready), 'b1000);
    @(negedge clk);
    chk("t2_port_b", 32'(pport), 3);
    chk("t2_addr_b", 32'(waddr), 1);
    chk("t2_data_b", 32'(wdata), 'h3333);
    valid[1] = 1'b1;
    data[16 +: 16] = 16'h1212;
    data[48 +: 16] = 16'h3434;
    @(negedge clk);
    chk("t2_ready_p1_r2", 32'(ready), 'b0010);
    @(negedge clk);
    chk("t2_port_c", 32'(pport), 1);
    chk("t2_data_c", 32'(wdata), 'h1212);
    valid[1] = 1'b0;
    @(negedge clk);
    chk("t2_ready_p3_r2", 32'(ready), 'b1000);
    @(negedge clk);
    chk("t2_port_d", 32'(pport), 3);
    chk("t2_addr_d", 32'(waddr), 3);
    valid = '0;
    last  = '0;

    // Port 2 arrives during port 0's burst and must wait
    push(0, 16'hD000, 1'b0);
    chk("t3_addr0", 32'(waddr), 4);
    valid[2] = 1'b1;
    last[2]  = 1'b1;
    data[32 +: 16] = 16'h2222;
    chk("t3_locked0", 32'(ready), 'b0001);
    push(0, 16'hD001, 1'b0);
    chk("t3_addr1", 32'(waddr), 5);
    chk("t3_data1", 32'(wdata), 'hD001);
    chk("t3_locked1", 32'(ready), 'b0001);
    push(0, 16'hD002, 1'b1);
    chk("t3_addr2", 32'(waddr), 6);
    chk("t3_done", 32'(done), 1);
    chk("t3_start", 32'(pstart), 4);
    chk("t3_len", 32'(plen), 3);
    chk("t3_bubble", 32'(ready), 0);
    @(negedge clk);
    chk("t3_ready_p2", 32'(ready), 'b0100);
    chk("t3_wen_gap", 32'(wen), 0);
    @(negedge clk);
    chk("t3_addr_p2", 32'(waddr), 7);
    chk("t3_data_p2", 32'(wdata), 'h2222);
    chk("t3_port_p2", 32'(pport), 2);
    chk("t3_start_p2", 32'(pstart), 7);
    chk("t3_len_p2", 32'(plen), 1);
    chk("t3_free", 32'(free), 8);
    valid = '0;
    last  = '0;

    // Fill the buffer, stall on full, resume after release
    do_reset();
    for (int i = 0; i < 16; i++) begin
      push(1, 16'h0100 + 16'(i), (i == 15));
      chk("t4_fill_addr", 32'(waddr), 32'(i));
    end
    chk("t4_done", 32'(done), 1);
    chk("t4_len", 32'(plen), 16);
    chk("t4_start", 32'(pstart), 0);
    chk("t4_free0", 32'(free), 0);
    valid[1] = 1'b1;
    last[1]  = 1'b1;
    data[16 +: 16] = 16'hABCD;
    repeat (3) @(negedge clk);
    chk("t4_full_ready", 32'(ready), 0);
    chk("t4_full_free", 32'(free), 0);
    chk("t4_full_wen", 32'(wen), 0);
    rel = 5'd2;
    @(negedge clk);
    rel = '0;
    chk("t4_rel_free", 32'(free), 2);
    chk("t4_rel_ready", 32'(ready), 'b0010);
    @(negedge clk);
    chk("t4_wrap_wen", 32'(wen), 1);
    chk("t4_wrap_addr", 32'(waddr), 0);
    chk("t4_wrap_data", 32'(wdata), 'hABCD);
    chk("t4_wrap_free", 32'(free), 1);
    chk("t4_wrap_len", 32'(plen), 1);
    valid = '0;
    last  = '0;

    // Packet that wraps from address 14
    do_reset();
    for (int i = 0; i < 14; i++) push(2, 16'h0200 + 16'(i), (i == 13));
    chk("t5_pre_len", 32'(plen), 14);
    chk("t5_pre_free", 32'(free), 2);
    rel = 5'd14;
    @(negedge clk);
    rel = '0;
    chk("t5_rel_free", 32'(free), 16);
    push(3, 16'hE000, 1'b0);
    chk("t5_addr14", 32'(waddr), 14);
    push(3, 16'hE001, 1'b0);
    chk("t5_addr15", 32'(waddr), 15);
    push(3, 16'hE002, 1'b0);
    chk("t5_addr0", 32'(waddr), 0);
    push(3, 16'hE003, 1'b1);
    chk("t5_addr1", 32'(waddr), 1);
    chk("t5_data1", 32'(wdata), 'hE003);
    chk("t5_done", 32'(done), 1);
    chk("t5_port", 32'(pport), 3);
    chk("t5_start", 32'(pstart), 14);
    chk("t5_len", 32'(plen), 4);
    chk("t5_free", 32'(free), 12);
    rel = 5'd16;
    @(negedge clk);
    rel = '0;
    chk("t5_clamp", 32'(free), 16);

    // Reset in the middle of a burst
    push(0, 16'hF000, 1'b0);
    push(0, 16'hF001, 1'b0);
    chk("t6_pre_addr", 32'(waddr), 3);
    chk("t6_pre_wen", 32'(wen), 1);
    rst_n = 1'b0;
    valid = '0;
    last  = '0;
    #1;
    chk("t6_async_wen", 32'(wen), 0);
    chk("t6_async_waddr", 32'(waddr), 0);
    chk("t6_async_ready", 32'(ready), 0);
    chk("t6_async_free", 32'(free), 16);
    chk("t6_async_start", 32'(pstart), 0);
    @(negedge clk);
    chk("t6_no_done", 32'(done), 0);
    rst_n = 1'b1;
    push(0, 16'hF002, 1'b1);
    chk("t6_addr", 32'(waddr), 0);
    chk("t6_data", 32'(wdata), 'hF002);
    chk("t6_done", 32'(done), 1);
    chk("t6_start", 32'(pstart), 0);
    chk("t6_len", 32'(plen), 1);

`ifdef BUFFER_WRITE_ARBITER_STATS_EN
    @(negedge clk);
    chk("st_words", swords, 1);
    chk("st_pkts", spkts, 1);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    chk("st_words_clr", swords, 0);
    chk("st_pkts_clr", spkts, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
